// File: rtl/ysyx_22051013_icache_axi_rd.sv
// Single-beat AXI4 read master that services i-cache miss refills (one AR/R per request).
// Optional debug timeout abort: define YSYX_22051013_AXI_RD_TIMEOUT_EN.
module ysyx_22051013_icache_axi_rd #(
  parameter int REQ_AW      = 64,
  parameter int AXI_AW      = 32,
  parameter int DATA_W      = 64,
  parameter int AXI_ID      = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_en,
  input  logic [REQ_AW-1:0] req_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              arvalid,
  input  logic              arready,
  output logic [AXI_AW-1:0] araddr,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [3:0]        rid
);

  localparam logic [3:0] ARID_C = 4'(AXI_ID);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Any non-OKAY response, foreign id or missing last flag poisons the refill beat.
  function automatic logic rd_err_f(input logic [1:0] resp, input logic [3:0] id,
                                    input logic last);
    rd_err_f = (resp != 2'b00) | (id != ARID_C) | ~last;
  endfunction

  state_e              state_r, state_nxt_s;
  logic                arvalid_r, arvalid_nxt_s;
  logic                rready_r, rready_nxt_s;
  logic                rsp_valid_r, rsp_valid_nxt_s;
  logic                rsp_err_r, rsp_err_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic [DATA_W-1:0]   rsp_data_r, rsp_data_nxt_s;
  logic [AXI_AW-1:0]   araddr_r, araddr_nxt_s;
  logic                accept_s;
  logic                ar_hs_s;
  logic                r_hs_s;
  logic                timeout_s;
  logic                unused_s;

  // The pulse cycle itself blocks acceptance, so a req_en still held from
  // the finished refill cannot launch a duplicate transaction.
  assign accept_s = req_en & ~rsp_valid_r;
  assign ar_hs_s  = arvalid_r & arready;
  assign r_hs_s   = rvalid & rready_r;
  assign unused_s = ^{req_addr[REQ_AW-1:AXI_AW], req_addr[2:0]};

`ifdef YSYX_22051013_AXI_RD_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TMO_W-1:0] tmo_cnt_r;

  // Transaction age counter: cleared on AR entry, counts through AR and R.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if ((state_r == ST_AR) || (state_r == ST_R)) begin
      tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Abort on the edge at which the count would reach TIMEOUT_CYC.
  assign timeout_s = ((state_r == ST_AR) || (state_r == ST_R)) &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));
`else
  logic [31:0] unused_tmo_s;
  assign unused_tmo_s = 32'(TIMEOUT_CYC);
  assign timeout_s    = 1'b0;
`endif

  // State and registered output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      araddr_r    <= {AXI_AW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      arvalid_r   <= arvalid_nxt_s;
      rready_r    <= rready_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
      busy_r      <= busy_nxt_s;
      rsp_data_r  <= rsp_data_nxt_s;
      araddr_r    <= araddr_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_AR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_AR: begin
        if (timeout_s) begin
          state_nxt_s = ST_RESP;
        end else if (ar_hs_s) begin
          state_nxt_s = ST_R;
        end else begin
          state_nxt_s = ST_AR;
        end
      end
      ST_R: begin
        if (timeout_s) begin
          state_nxt_s = ST_RESP;
        end else if (r_hs_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_R;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    arvalid_nxt_s   = arvalid_r;
    rready_nxt_s    = rready_r;
    rsp_valid_nxt_s = 1'b0;
    rsp_err_nxt_s   = rsp_err_r;
    rsp_data_nxt_s  = rsp_data_r;
    araddr_nxt_s    = araddr_r;
    busy_nxt_s      = (state_nxt_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        rready_nxt_s = 1'b0;
        if (accept_s) begin
          arvalid_nxt_s = 1'b1;
          araddr_nxt_s  = {req_addr[AXI_AW-1:3], 3'b000};
        end else begin
          arvalid_nxt_s = 1'b0;
        end
      end
      ST_AR: begin
        // req_en is ignored here: once raised, arvalid is never withdrawn.
        if (timeout_s) begin
          arvalid_nxt_s  = 1'b0;
          rsp_data_nxt_s = {DATA_W{1'b0}};
          rsp_err_nxt_s  = 1'b1;
        end else if (ar_hs_s) begin
          arvalid_nxt_s = 1'b0;
          rready_nxt_s  = 1'b1;
        end else begin
          arvalid_nxt_s = 1'b1;
        end
      end
      ST_R: begin
        if (timeout_s) begin
          rready_nxt_s   = 1'b0;
          rsp_data_nxt_s = {DATA_W{1'b0}};
          rsp_err_nxt_s  = 1'b1;
        end else if (r_hs_s) begin
          rready_nxt_s   = 1'b0;
          rsp_data_nxt_s = rdata;
          rsp_err_nxt_s  = rd_err_f(rresp, rid, rlast);
        end else begin
          rready_nxt_s = 1'b1;
        end
      end
      ST_RESP: begin
        arvalid_nxt_s   = 1'b0;
        rready_nxt_s    = 1'b0;
        rsp_valid_nxt_s = 1'b1;
      end
      default: begin
        arvalid_nxt_s = 1'b0;
        rready_nxt_s  = 1'b0;
      end
    endcase
  end

  assign arvalid   = arvalid_r;
  assign rready    = rready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = busy_r;
  assign araddr    = araddr_r;
  assign arid      = ARID_C;
  assign arlen     = 8'd0;
  assign arsize    = 3'b011;
  assign arburst   = 2'b01;

endmodule

// File: tb/tb_ysyx_22051013_icache_axi_rd.sv
// Directed bench for the i-cache AXI read master: latency, stalls, errors,
// back-to-back refills, mid-transaction reset and the AR wait/timeout behaviour.
module tb_ysyx_22051013_icache_axi_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_en;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int n_vec = 0;
  int n_err = 0;

  int          ar_hs_cnt    = 0;
  int          rsp_cnt      = 0;
  logic [31:0] last_ar_addr = 32'd0;

  ysyx_22051013_icache_axi_rd #(.TIMEOUT_CYC(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_en   (req_en),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .arvalid  (arvalid),
    .arready  (arready),
    .araddr   (araddr),
    .arid     (arid),
    .arlen    (arlen),
    .arsize   (arsize),
    .arburst  (arburst),
    .rvalid   (rvalid),
    .rready   (rready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rlast    (rlast),
    .rid      (rid)
  );

  always #5 clk = ~clk;

  // Handshake / pulse monitor.
  always @(posedge clk) begin
    if (!rst && arvalid && arready) begin
      ar_hs_cnt    <= ar_hs_cnt + 1;
      last_ar_addr <= araddr;
    end
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Zero-wait refill with a chosen response; checks the 4-cycle pulse and the lockout cycle.
  task automatic run_tied(input string tag, input logic [63:0] addr, input logic [63:0] d,
                          input logic [1:0] resp, input logic last, input logic [3:0] id,
                          input logic exp_err);
    arready = 1'b1; rvalid = 1'b1;
    rdata = d; rresp = resp; rlast = last; rid = id;
    req_en = 1'b1; req_addr = addr;
    tick(); tick(); tick();
    chk({tag, "_pre"}, rsp_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_data"}, rsp_data, d);
    chk({tag, "_err"}, rsp_err, exp_err);
    tick();
    chk({tag, "_lockout"}, arvalid, 1'b0);
    req_en = 1'b0; rresp = 2'b00; rlast = 1'b1; rid = 4'd0;
    tick();
  endtask

  initial begin
    int a0, r0, held;
    logic got;

    rst = 1'b1; req_en = 1'b0; req_addr = 64'd0;
    arready = 1'b0; rvalid = 1'b0; rdata = 64'd0;
    rresp = 2'b00; rlast = 1'b1; rid = 4'd0;
    tick(); tick();
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("arid", arid, 4'd0);
    chk("arlen", arlen, 8'd0);
    chk("arsize", arsize, 3'd3);
    chk("arburst", arburst, 2'b01);
    rst = 1'b0;
    tick();

    // Minimum latency with slave always ready.
    arready = 1'b1; rvalid = 1'b1;
    rdata = 64'h0000_0013_0000_0093; rresp = 2'b00; rlast = 1'b1; rid = 4'd0;
    req_en = 1'b1; req_addr = 64'h0000_0000_8000_0004;
    tick();
    chk("t1_arvalid", arvalid, 1'b1);
    chk("t1_araddr", araddr, 32'h8000_0000);
    chk("t1_busy", busy, 1'b1);
    tick();
    chk("t1_rready", rready, 1'b1);
    chk("t1_arvalid_low", arvalid, 1'b0);
    tick();
    chk("t1_no_early_rsp", rsp_valid, 1'b0);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp_data", rsp_data, 64'h0000_0013_0000_0093);
    chk("t1_rsp_err", rsp_err, 1'b0);
    chk("t1_busy_idle", busy, 1'b0);
    tick();
    chk("t1_lockout_arvalid", arvalid, 1'b0);
    chk("t1_pulse_one", rsp_valid, 1'b0);
    req_en = 1'b0;
    tick();
    chk("t1_data_hold", rsp_data, 64'h0000_0013_0000_0093);
    chk("t1_idle_arvalid", arvalid, 1'b0);

    // arready delayed, req_en dropped while in AR.
    a0 = ar_hs_cnt; r0 = rsp_cnt;
    arready = 1'b0; rdata = 64'h1111_2222_3333_4444;
    req_en = 1'b1; req_addr = 64'h0000_0000_8000_0123;
    tick();
    chk("t2_arvalid", arvalid, 1'b1);
    chk("t2_araddr", araddr, 32'h8000_0120);
    tick();
    req_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_arvalid_hold", arvalid, 1'b1);
      chk("t2_araddr_hold", araddr, 32'h8000_0120);
    end
    arready = 1'b1;
    tick();
    chk("t2_rready", rready, 1'b1);
    arready = 1'b0;
    tick();
    tick();
    chk("t2_rsp_valid", rsp_valid, 1'b1);
    chk("t2_rsp_data", rsp_data, 64'h1111_2222_3333_4444);
    tick(); tick(); tick();
    chk("t2_no_second_ar", arvalid, 1'b0);
    chk("t2_ar_count", ar_hs_cnt - a0, 1);
    chk("t2_rsp_count", rsp_cnt - r0, 1);

    // rvalid delayed, SLVERR response.
    arready = 1'b1; rvalid = 1'b0; rresp = 2'b10; rdata = 64'hDEAD_BEEF_0BAD_F00D;
    req_en = 1'b1; req_addr = 64'h0000_0000_8000_0010;
    tick(); tick();
    chk("t3_rready", rready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_rready_wait", rready, 1'b1);
      chk("t3_no_rsp", rsp_valid, 1'b0);
    end
    rvalid = 1'b1;
    tick();
    chk("t3_rready_drop", rready, 1'b0);
    tick();
    chk("t3_rsp_valid", rsp_valid, 1'b1);
    chk("t3_rsp_err", rsp_err, 1'b1);
    chk("t3_rsp_data", rsp_data, 64'hDEAD_BEEF_0BAD_F00D);
    tick();
    req_en = 1'b0; rresp = 2'b00;
    tick();

    // Other error sources and a clean recovery.
    run_tied("e_rid", 64'h0000_0000_8000_0100, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b1, 4'h3, 1'b1);
    run_tied("e_last", 64'h0000_0000_8000_0108, 64'h0F0F_0F0F_F0F0_F0F0, 2'b00, 1'b0, 4'h0, 1'b1);
    run_tied("e_exok", 64'h0000_0000_8000_0110, 64'h5555_AAAA_5555_AAAA, 2'b01, 1'b1, 4'h0, 1'b1);
    run_tied("ok", 64'h0000_0000_8000_0118, 64'hCAFE_F00D_1234_5678, 2'b00, 1'b1, 4'h0, 1'b0);

    // Cache-style back-to-back refills.
    a0 = ar_hs_cnt; r0 = rsp_cnt;
    arready = 1'b1; rvalid = 1'b1; rdata = 64'hAAAA_0000_0000_0001;
    req_en = 1'b1; req_addr = 64'h0000_0000_8000_0000;
    tick(); tick(); tick(); tick();
    chk("t4_first_rsp", rsp_valid, 1'b1);
    chk("t4_first_data", rsp_data, 64'hAAAA_0000_0000_0001);
    tick();
    chk("t4_lockout", arvalid, 1'b0);
    rdata = 64'hBBBB_0000_0000_0002; req_addr = 64'h0000_0000_8000_0008;
    tick();
    chk("t4_second_arvalid", arvalid, 1'b1);
    chk("t4_second_araddr", araddr, 32'h8000_0008);
    tick(); tick(); tick();
    chk("t4_second_rsp", rsp_valid, 1'b1);
    chk("t4_second_data", rsp_data, 64'hBBBB_0000_0000_0002);
    tick();
    req_en = 1'b0;
    tick();
    chk("t4_ar_count", ar_hs_cnt - a0, 2);
    chk("t4_last_addr", last_ar_addr, 32'h8000_0008);
    chk("t4_rsp_count", rsp_cnt - r0, 2);

    // Reset while waiting in R.
    arready = 1'b1; rvalid = 1'b0;
    req_en = 1'b1; req_addr = 64'h0000_0000_8000_0020;
    tick(); tick();
    chk("t5_in_r", rready, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_arvalid", arvalid, 1'b0);
    chk("t5_rready", rready, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_rsp_valid", rsp_valid, 1'b0);
    rvalid = 1'b1; rdata = 64'h7777_6666_5555_4444;
    tick();
    chk("t5_re_arvalid", arvalid, 1'b1);
    chk("t5_re_araddr", araddr, 32'h8000_0020);
    tick(); tick(); tick();
    chk("t5_rsp_valid2", rsp_valid, 1'b1);
    chk("t5_rsp_data", rsp_data, 64'h7777_6666_5555_4444);
    chk("t5_rsp_err", rsp_err, 1'b0);
    tick();
    req_en = 1'b0;
    tick();

    // Slave never accepts the address.
    arready = 1'b0; rvalid = 1'b1; rdata = 64'h9999_8888_7777_6666;
    req_en = 1'b1; req_addr = 64'h0000_0000_8000_0040;
    tick();
    chk("t6_arvalid", arvalid, 1'b1);
`ifdef YSYX_22051013_AXI_RD_TIMEOUT_EN
    held = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (arvalid) held++;
    end
    chk("t6_held_before_tmo", held, 15);
    tick();
    chk("t6_tmo_arvalid", arvalid, 1'b0);
    chk("t6_tmo_busy", busy, 1'b1);
    tick();
    chk("t6_tmo_rsp_valid", rsp_valid, 1'b1);
    chk("t6_tmo_rsp_err", rsp_err, 1'b1);
    chk("t6_tmo_rsp_data", rsp_data, 64'd0);
    tick();
    req_en = 1'b0;
    tick();
    chk("t6_tmo_idle", busy, 1'b0);
`else
    held = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (arvalid && araddr == 32'h8000_0040) held++;
    end
    chk("t6_arvalid_held", held, 120);
    chk("t6_no_rsp", rsp_valid, 1'b0);
    arready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (rsp_valid) got = 1'b1;
    end
    chk("t6_late_rsp_seen", got, 1'b1);
    chk("t6_late_rsp_data", rsp_data, 64'h9999_8888_7777_6666);
    req_en = 1'b0;
    tick();
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22051013_icache_axi_rd.md
Name: ysyx_22051013_icache_axi_rd

Overview:
Single-beat AXI4 read master that sits directly downstream of the instruction cache and services its miss refills.
- Accepts a level-held request (req_en plus address) from the i-cache miss path.
- Issues one 64-bit AR/R transaction.
- Returns the beat on a one-cycle rsp_valid pulse, which the cache uses as its refill-write strobe.

Parameters:
REQ_AW, 64, width of request address from cache (PC width)
AXI_AW, 32, AXI araddr width; taken from req_addr[AXI_AW-1:0]
DATA_W, 64, AXI rdata / response data width
AXI_ID, 0, constant value driven on arid (4 bits)
TIMEOUT_CYC, 255, cycles before timeout abort (only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_en  in  1  refill request, held high by cache until rsp_valid
req_addr  in  REQ_AW  refill address; bits [2:0] ignored
rsp_valid  out  1  one-cycle pulse: rsp_data/rsp_err valid
rsp_data  out  DATA_W  returned 64-bit beat
rsp_err  out  1  rresp != OKAY, rid mismatch, or timeout
busy  out  1  high in every state except IDLE
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
araddr  out  AXI_AW  AXI AR address, 8-byte aligned
arid  out  4  = AXI_ID
arlen  out  8  = 0
arsize  out  3  = 3'b011
arburst  out  2  = 2'b01 (INCR)
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
rdata  in  DATA_W  AXI R data
rresp  in  2  AXI R response
rlast  in  1  AXI R last
rid  in  4  AXI R id

Behaviour:
- All control outputs are registered. Reset (synchronous, rst=1 at posedge) forces:
  - state=IDLE; arvalid=0, rready=0, rsp_valid=0, rsp_err=0, busy=0.
  - rsp_data=0, araddr=0.
- FSM states: IDLE, AR, R, RESP.
- IDLE:
  - If req_en=1, latch araddr = {req_addr[AXI_AW-1:3],3'b000}, set arvalid=1, go to AR.
  - A request can be issued at the earliest 1 cycle after req_en rises.
- AR:
  - Hold arvalid and araddr stable until arvalid&arready.
  - On handshake: arvalid=0, rready=1, go to R.
  - req_en dropping in AR does not withdraw arvalid (AXI rule); the transaction completes.
- R:
  - On rvalid&rready: rsp_data<=rdata; rready=0.
  - rsp_err<=(rresp!=2'b00)|(rid!=AXI_ID)|~rlast.
  - Go to RESP.
  - rvalid coincident with the AR handshake cycle cannot occur because rready=0 in AR; no special case.
- RESP:
  - rsp_valid=1 for exactly one cycle, then go to IDLE.
  - Minimum latency: req_en high to rsp_valid = 4 cycles (arready and rvalid both already high).
- After RESP, the IDLE state always spends at least one cycle before accepting a new request. This guarantees no duplicate refill while the cache clears req_en the cycle after rsp_valid.
- rsp_data and rsp_err hold their value until the next R capture; only rsp_valid qualifies them.
- If req_en is low at RESP, the response is still pulsed; the requester ignores it.
- Only one outstanding transaction. No back-to-back pipelining.
- Reset mid-operation returns to IDLE immediately. The AXI slave is reset on the same rst, so no orphan beat is expected.
- busy=1 in AR, R, RESP.

Optional Feature:
- Macro: YSYX_22051013_AXI_RD_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on entry to AR and increments each cycle in AR/R.
  - When it reaches TIMEOUT_CYC: drop arvalid/rready, load rsp_data=0, rsp_err=1, go to RESP.
  - Intended as a debug aid only; it violates the AXI valid-hold rule.
- Undefined: no counter logic; the FSM waits indefinitely in AR/R.

Test Plan:
- arready, rvalid tied high; req_en=1, req_addr=0x0000_0000_8000_0004, rdata=0x0000_0013_0000_0093, rresp=0, rlast=1, rid=0:
  - araddr=0x8000_0000, arlen=0, arsize=3.
  - rsp_valid pulses 4 cycles after req_en with rsp_data=0x0000_0013_0000_0093, rsp_err=0.
- arready delayed 5 cycles and req_en dropped on cycle 2:
  - arvalid/araddr stay stable until handshake; rsp_valid still pulses once; no second AR issued.
- rvalid delayed 7 cycles after AR, and rresp=2'b10:
  - rready stays high while waiting; rsp_valid pulses once with rsp_err=1 and rsp_data=rdata.
- Cache-style back-to-back: req_en rises again 1 cycle after rsp_valid, addr 0x8000_0008:
  - Exactly two AR handshakes total; second araddr=0x8000_0008; no duplicate for the first address.
- rst asserted for 1 cycle while in R:
  - Next cycle arvalid=0, rready=0, busy=0, rsp_valid=0; a new request afterwards completes normally.
- With YSYX_22051013_AXI_RD_TIMEOUT_EN and TIMEOUT_CYC=16, arready held 0:
  - After 16 cycles in AR, arvalid=0 and rsp_valid pulses with rsp_err=1, rsp_data=0.
  - Without the macro, arvalid stays high for 100+ cycles.
